// File: rtl/alu_pkg.sv
// Shared types, widths and amount normalisation for the rotate issue stage.
package alu_pkg;

  localparam int ROT_W = 16;
  localparam int AMT_W = 4;

  typedef enum logic [1:0] {ACTIVE, SLEEP, WAKE} state_e;

  typedef struct packed {
    logic [ROT_W-1:0] data;
    logic [AMT_W-1:0] ctrl;
    logic             dir;
  } entry_t;

  // A right rotate by n equals a left rotate by (-n) mod 16.
  function automatic logic [AMT_W-1:0] rot_amt_to_left(input logic [AMT_W-1:0] amt,
                                                      input logic             dir);
    return dir ? (AMT_W'(0) - amt) : amt;
  endfunction

endpackage

// File: rtl/alu_rotate_issue_if.sv
// Request and rotator-side signals of the rotate issue stage.
interface alu_rotate_issue_if;
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ROT_W-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [ROT_W-1:0] out_data;
  logic [AMT_W-1:0] out_ctrl;
  logic             out_dir;
  logic             gate_en;

  modport master (
    output in_valid, in_data, in_amt, in_dir, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_dir, gate_en
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_dir, gate_en
  );

endinterface

// File: rtl/alu_issue_fifo2.sv
// Two-entry FIFO whose head is a dedicated register that only changes on a transfer.
module alu_issue_fifo2
  import alu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  entry_t i_entry,
  input  logic   i_pop,
  output logic [1:0] o_count,
  output entry_t o_head
);

  entry_t     r_mem [2];
  entry_t     r_head;
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  entry_t     w_head_d;
  logic       w_rd_ptr_d;
  logic [1:0] w_count_d;

  always_comb begin
    w_rd_ptr_d = r_rd_ptr ^ i_pop;
    w_count_d  = r_count + {1'b0, i_push} - {1'b0, i_pop};
    w_head_d   = r_head;
    // Empty after this edge: keep the last head so the rotator inputs stay quiet.
    if (w_count_d != 2'd0) begin
      if (i_push && (w_rd_ptr_d == r_wr_ptr)) begin
        w_head_d = i_entry;
      end else begin
        w_head_d = r_mem[w_rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '{default: '0};
      r_head   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_entry;
      end
      r_head   <= w_head_d;
      r_wr_ptr <= r_wr_ptr ^ i_push;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/alu_rotate_issue.sv
// Rotate operand issue stage: handshake, left-amount normalisation, FIFO and idle clock gating.
module alu_rotate_issue
  import alu_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 8
) (
  input logic               clk,
  input logic               rst,
  alu_rotate_issue_if.slave io_bus
);

  localparam logic [7:0] IdleLast = 8'(IDLE_CYCLES - 1);

  state_e     r_state;
  state_e     w_state_d;
  logic [7:0] r_idle_cnt;
  logic [7:0] w_idle_cnt_d;
  logic       r_gate_en;
  logic [1:0] w_count;
  logic       w_push;
  logic       w_pop;
  logic       w_idle;
  entry_t     w_entry;
  entry_t     w_head;

  assign io_bus.in_ready  = (r_state == ACTIVE) && (w_count < 2'd2);
  assign io_bus.out_valid = (w_count != 2'd0);
  assign w_push           = io_bus.in_valid && io_bus.in_ready;
  assign w_pop            = io_bus.out_valid && io_bus.out_ready;
  assign w_idle           = (w_count == 2'd0) && !io_bus.in_valid;

  assign w_entry = '{data: io_bus.in_data,
                     ctrl: rot_amt_to_left(io_bus.in_amt, io_bus.in_dir),
                     dir:  io_bus.in_dir};

  alu_issue_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign io_bus.out_data = w_head.data;
  assign io_bus.out_ctrl = w_head.ctrl;
  assign io_bus.out_dir  = w_head.dir;
  assign io_bus.gate_en  = r_gate_en;

  always_comb begin
    w_state_d    = r_state;
    w_idle_cnt_d = r_idle_cnt;
    unique case (r_state)
      ACTIVE: begin
        if (!w_idle) begin
          w_idle_cnt_d = 8'd0;
        end else if (r_idle_cnt >= IdleLast) begin
          w_state_d    = SLEEP;
          w_idle_cnt_d = 8'd0;
        end else begin
          w_idle_cnt_d = r_idle_cnt + 8'd1;
        end
      end
      SLEEP: begin
        if (io_bus.in_valid) begin
          w_state_d = WAKE;
        end
      end
      WAKE:    w_state_d = ACTIVE;
      default: w_state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ACTIVE;
      r_idle_cnt <= 8'd0;
      r_gate_en  <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_idle_cnt <= w_idle_cnt_d;
      r_gate_en  <= (w_state_d != SLEEP);
    end
  end

endmodule

// File: tb/tb_alu_rotate_issue.sv
// Directed bench for alu_rotate_issue with IDLE_CYCLES=4.
module tb_alu_rotate_issue;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   toggles;
  logic [20:0] prev_out;

  alu_rotate_issue_if bus_if ();

  alu_rotate_issue #(
    .IDLE_CYCLES (4)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] a, input logic dr);
    bus_if.in_valid = v;
    bus_if.in_data  = d;
    bus_if.in_amt   = a;
    bus_if.in_dir   = dr;
  endtask

  task automatic check_head(input string tag, input logic [15:0] d, input logic [3:0] c,
                            input logic dr);
    check({tag, "_valid"}, 32'(bus_if.out_valid), 1);
    check({tag, "_data"}, 32'(bus_if.out_data), 32'(d));
    check({tag, "_ctrl"}, 32'(bus_if.out_ctrl), 32'(c));
    check({tag, "_dir"}, 32'(bus_if.out_dir), 32'(dr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    bus_if.out_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", 32'(bus_if.in_ready), 1);
    check("rst_out_valid", 32'(bus_if.out_valid), 0);
    check("rst_out_data", 32'(bus_if.out_data), 0);
    check("rst_out_ctrl", 32'(bus_if.out_ctrl), 0);
    check("rst_out_dir", 32'(bus_if.out_dir), 0);
    check("rst_gate_en", 32'(bus_if.gate_en), 1);
    step();
    step();
    rst = 1'b0;

    // ROL 3, ROR 1, ROR 0 with the rotator always ready
    bus_if.out_ready = 1'b1;
    drive(1'b1, 16'h8001, 4'd3, 1'b0);
    step();
    check_head("rol3", 16'h8001, 4'd3, 1'b0);
    drive(1'b1, 16'h8001, 4'd1, 1'b1);
    step();
    check_head("ror1", 16'h8001, 4'd15, 1'b1);
    drive(1'b1, 16'hABCD, 4'd0, 1'b1);
    step();
    check_head("ror0", 16'hABCD, 4'd0, 1'b1);
    bus_if.in_valid = 1'b0;
    step();
    check("drain_valid", 32'(bus_if.out_valid), 0);
    check("drain_hold", 32'(bus_if.out_data), 'hABCD);

    // Backpressure: three requests against a stalled rotator
    bus_if.out_ready = 1'b0;
    drive(1'b1, 16'h1111, 4'd2, 1'b0);
    check("bp_ready0", 32'(bus_if.in_ready), 1);
    step();
    drive(1'b1, 16'h2222, 4'd5, 1'b1);
    check("bp_ready1", 32'(bus_if.in_ready), 1);
    check_head("bp_d1", 16'h1111, 4'd2, 1'b0);
    step();
    drive(1'b1, 16'h3333, 4'd7, 1'b0);
    check("bp_full_ready", 32'(bus_if.in_ready), 0);
    check("bp_full_data", 32'(bus_if.out_data), 'h1111);
    step();
    check("bp_stall_ready", 32'(bus_if.in_ready), 0);
    check("bp_stall_data", 32'(bus_if.out_data), 'h1111);
    bus_if.out_ready = 1'b1;
    step();
    check_head("bp_d2", 16'h2222, 4'd11, 1'b1);
    check("bp_ready_after_pop", 32'(bus_if.in_ready), 1);
    step();
    check_head("bp_d3", 16'h3333, 4'd7, 1'b0);
    bus_if.in_valid = 1'b0;
    step();
    check("bp_empty", 32'(bus_if.out_valid), 0);

    // Ten back-to-back beats with push and pop together at count 1
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 4'(i), i[0]);
      step();
      check_head("stream", 16'h1000 + 16'(i), i[0] ? 4'((16 - i) % 16) : 4'(i), i[0]);
      check("stream_ready", 32'(bus_if.in_ready), 1);
    end
    bus_if.in_valid = 1'b0;
    step();
    check("stream_empty", 32'(bus_if.out_valid), 0);

    // Fourth consecutive idle cycle enters SLEEP
    step();
    step();
    step();
    check("pre_sleep_gate", 32'(bus_if.gate_en), 1);
    check("pre_sleep_ready", 32'(bus_if.in_ready), 1);
    step();
    check("sleep_gate", 32'(bus_if.gate_en), 0);
    check("sleep_ready", 32'(bus_if.in_ready), 0);

    // Wake-up: SLEEP -> WAKE -> ACTIVE (accept) -> out_valid
    drive(1'b1, 16'h5A5A, 4'd4, 1'b1);
    step();
    check("wake_ready", 32'(bus_if.in_ready), 0);
    check("wake_gate", 32'(bus_if.gate_en), 1);
    check("wake_valid", 32'(bus_if.out_valid), 0);
    step();
    check("active_ready", 32'(bus_if.in_ready), 1);
    check("active_valid", 32'(bus_if.out_valid), 0);
    step();
    check_head("wake_out", 16'h5A5A, 4'd12, 1'b1);

    // Fill to two entries then reset mid-stream
    bus_if.out_ready = 1'b0;
    drive(1'b1, 16'h6B6B, 4'd0, 1'b0);
    step();
    check("full_ready", 32'(bus_if.in_ready), 0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus_if.out_valid), 0);
    check("mid_rst_data", 32'(bus_if.out_data), 0);
    check("mid_rst_ctrl", 32'(bus_if.out_ctrl), 0);
    check("mid_rst_gate", 32'(bus_if.gate_en), 1);
    bus_if.in_valid = 1'b0;
    step();
    rst = 1'b0;
    check("post_rst_ready", 32'(bus_if.in_ready), 1);
    check("post_rst_valid", 32'(bus_if.out_valid), 0);

    // Isolation: random payload with in_valid low must not reach the outputs
    bus_if.out_ready = 1'b1;
    drive(1'b1, 16'h7777, 4'd9, 1'b1);
    step();
    check_head("iso_load", 16'h7777, 4'd7, 1'b1);
    bus_if.in_valid = 1'b0;
    step();
    check("iso_empty", 32'(bus_if.out_valid), 0);
    prev_out = {bus_if.out_data, bus_if.out_ctrl, bus_if.out_dir};
    toggles  = 0;
    for (int i = 0; i < 50; i++) begin
      bus_if.in_data = 16'($urandom);
      bus_if.in_amt  = 4'($urandom_range(15));
      bus_if.in_dir  = 1'($urandom_range(1));
      step();
      if ({bus_if.out_data, bus_if.out_ctrl, bus_if.out_dir} != prev_out) toggles++;
      prev_out = {bus_if.out_data, bus_if.out_ctrl, bus_if.out_dir};
    end
    check("iso_toggles", 32'(toggles), 0);
    check("iso_data", 32'(bus_if.out_data), 'h7777);
    check("iso_sleep_gate", 32'(bus_if.gate_en), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
